// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter FSM states and fixed-burst beat lengths.
// Pure definitions only: no latency and no flow control of its own.
package ahb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] BEATS_4  = 5'd4;
  localparam logic [CNT_W-1:0] BEATS_8  = 5'd8;
  localparam logic [CNT_W-1:0] BEATS_16 = 5'd16;

  typedef enum logic [1:0] {
    ST_PARK  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2,
    ST_LOCK  = 2'd3
  } arb_state_t;

  // Zero for SINGLE/INCR, i.e. bursts whose length the arbiter does not track.
  function automatic logic [CNT_W-1:0] burst_beats(input logic [2:0] hburst);
    case (hburst[2:1])
      2'b01:   burst_beats = BEATS_4;
      2'b10:   burst_beats = BEATS_8;
      2'b11:   burst_beats = BEATS_16;
      default: burst_beats = '0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Round-robin picker: first set req bit searching upward from last_winner+1.
// Purely combinational, zero latency; valid low when no request is set.
module ahb_rr_pick #(
  parameter int N  = 3,
  parameter int MW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] last_winner,
  output logic [N-1:0]  grant,
  output logic [MW-1:0] index,
  output logic          valid
);

  int           pos;
  logic [N-1:0] shifted;

  always_comb begin
    grant   = '0;
    index   = '0;
    valid   = 1'b0;
    pos     = 0;
    shifted = '0;
    for (int k = 1; k <= N; k++) begin
      pos     = (int'(last_winner) + k) % N;
      shifted = req >> pos;
      if (!valid && shifted[0]) begin
        valid = 1'b1;
        index = MW'(pos);
        grant = {{(N-1){1'b0}}, 1'b1} << pos;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with burst tracking and locked sequences.
// Grant changes one edge after an arbitration point; HREADY=0 or BUSY freezes everything.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NO_OF_MANAGERS = 3,
  parameter int MW             = $clog2(NO_OF_MANAGERS)
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [NO_OF_MANAGERS-1:0] HBUSREQ,
  input  logic [NO_OF_MANAGERS-1:0] HLOCK,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HBURST,
  input  logic                      HREADY,
  output logic [NO_OF_MANAGERS-1:0] HGRANT,
  output logic [MW-1:0]             HMASTER,
  output logic [MW-1:0]             HMASTER_D,
  output logic                      HMASTLOCK
);

  localparam logic [NO_OF_MANAGERS-1:0] GRANT_PARK = {{(NO_OF_MANAGERS-1){1'b0}}, 1'b1};

  arb_state_t                state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [MW-1:0]             last_winner, last_winner_nxt;
  logic [NO_OF_MANAGERS-1:0] grant_nxt;
  logic [MW-1:0]             master_nxt;
  logic                      lock_nxt;

  logic                      hold, start_burst, final_beat, base_arb, arb;
  logic [NO_OF_MANAGERS-1:0] others, cand, pick_grant;
  logic [MW-1:0]             pick_idx;
  logic                      pick_vld;

  assign hold        = !HREADY || (HTRANS == TRANS_BUSY);
  assign start_burst = (HTRANS == TRANS_NONSEQ) && (HBURST[2:1] != 2'b00);
  assign final_beat  = (state == ST_BURST) && (HTRANS == TRANS_SEQ) && (cnt == 5'd1);
  assign base_arb    = (state == ST_PARK) || (HTRANS == TRANS_IDLE) ||
                       ((HTRANS == TRANS_NONSEQ) && (HBURST == BURST_SINGLE)) ||
                       ((state == ST_OWN) && (HBURST == BURST_INCR) && !HBUSREQ[HMASTER]) ||
                       final_beat;
  assign arb         = !hold && base_arb && !((state == ST_LOCK) && HLOCK[HMASTER]);

  // The current owner only competes when nobody else is asking.
  assign others = HBUSREQ & ~HGRANT;
  assign cand   = (others != '0) ? others : HBUSREQ;

  ahb_rr_pick #(.N(NO_OF_MANAGERS), .MW(MW)) u_pick (
    .req         (cand),
    .last_winner (last_winner),
    .grant       (pick_grant),
    .index       (pick_idx),
    .valid       (pick_vld)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state       <= ST_PARK;
      cnt         <= '0;
      last_winner <= MW'(NO_OF_MANAGERS - 1);
      HGRANT      <= GRANT_PARK;
      HMASTER     <= '0;
      HMASTER_D   <= '0;
      HMASTLOCK   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last_winner <= last_winner_nxt;
      HGRANT      <= grant_nxt;
      HMASTER     <= master_nxt;
      HMASTLOCK   <= lock_nxt;
      if (HREADY) HMASTER_D <= HMASTER;
    end
  end

  // cnt counts SEQ beats still owed after the accepted NONSEQ, so the last beat sees 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (arb) begin
      cnt_nxt = '0;
      if (!pick_vld) begin
        state_nxt = ST_PARK;
      end else if (HLOCK[pick_idx]) begin
        state_nxt = ST_LOCK;
      end else if (start_burst && (pick_idx == HMASTER)) begin
        state_nxt = ST_BURST;
        cnt_nxt   = burst_beats(HBURST) - 5'd1;
      end else begin
        state_nxt = ST_OWN;
      end
    end else if (!hold && (state != ST_LOCK)) begin
      if (start_burst) begin
        state_nxt = ST_BURST;
        cnt_nxt   = burst_beats(HBURST) - 5'd1;
      end else if ((state == ST_BURST) && (HTRANS == TRANS_SEQ)) begin
        cnt_nxt = cnt - 5'd1;
      end else if (state == ST_BURST) begin
        state_nxt = ST_OWN;
        cnt_nxt   = '0;
      end
    end
  end

  always_comb begin
    grant_nxt       = HGRANT;
    master_nxt      = HMASTER;
    lock_nxt        = HMASTLOCK;
    last_winner_nxt = last_winner;
    if (arb) begin
      if (pick_vld) begin
        grant_nxt       = pick_grant;
        master_nxt      = pick_idx;
        lock_nxt        = HLOCK[pick_idx];
        last_winner_nxt = pick_idx;
      end else begin
        grant_nxt  = GRANT_PARK;
        master_nxt = '0;
        lock_nxt   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter with three managers; expectations are hand-derived.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  logic       HCLK;
  logic       HRESET;
  logic [2:0] HBUSREQ;
  logic [2:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [2:0] HGRANT;
  logic [1:0] HMASTER;
  logic [1:0] HMASTER_D;
  logic       HMASTLOCK;

  int n_cmp = 0;
  int n_err = 0;

  ahb_arbiter dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D),
    .HMASTLOCK (HMASTLOCK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic apply_reset();
    HRESET  = 1'b1;
    HBUSREQ = 3'b000;
    HLOCK   = 3'b000;
    HTRANS  = TRANS_IDLE;
    HBURST  = BURST_SINGLE;
    HREADY  = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    HRESET  = 1'b1;
    HBUSREQ = 3'b111;
    HLOCK   = 3'b111;
    HTRANS  = TRANS_NONSEQ;
    HBURST  = BURST_SINGLE;
    HREADY  = 1'b1;
    tick();
    tick();
    n_cmp++; if (HGRANT !== 3'b001) begin n_err++; $display("FAIL reset_grant got %b want 001", HGRANT); end
    n_cmp++; if (HMASTER !== 2'd0) begin n_err++; $display("FAIL reset_master got %0d want 0", HMASTER); end
    n_cmp++; if (HMASTER_D !== 2'd0) begin n_err++; $display("FAIL reset_master_d got %0d want 0", HMASTER_D); end
    n_cmp++; if (HMASTLOCK !== 1'b0) begin n_err++; $display("FAIL reset_lock got %b want 0", HMASTLOCK); end
    n_cmp++; if (dut.state !== ST_PARK) begin n_err++; $display("FAIL reset_state got %0d want PARK", dut.state); end
    n_cmp++; if (dut.last_winner !== 2'd2) begin n_err++; $display("FAIL reset_last got %0d want 2", dut.last_winner); end
    HRESET  = 1'b0;
    HBUSREQ = 3'b000;
    HLOCK   = 3'b000;
    HTRANS  = TRANS_IDLE;
    tick();
    n_cmp++; if (HGRANT !== 3'b001) begin n_err++; $display("FAIL noreq_grant got %b want 001", HGRANT); end
    n_cmp++; if (dut.state !== ST_PARK) begin n_err++; $display("FAIL noreq_state got %0d want PARK", dut.state); end
    n_cmp++; if (dut.last_winner !== 2'd2) begin n_err++; $display("FAIL noreq_last got %0d want 2", dut.last_winner); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_m [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic [1:0] exp_d [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [2:0] exp_g;
    apply_reset();
    HBUSREQ = 3'b111;
    HTRANS  = TRANS_NONSEQ;
    HBURST  = BURST_SINGLE;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_g = 3'b001 << exp_m[i];
      n_cmp++; if (HMASTER !== exp_m[i]) begin n_err++; $display("FAIL rr_master[%0d] got %0d want %0d", i, HMASTER, exp_m[i]); end
      n_cmp++; if (HGRANT !== exp_g) begin n_err++; $display("FAIL rr_grant[%0d] got %b want %b", i, HGRANT, exp_g); end
      n_cmp++; if (HMASTER_D !== exp_d[i]) begin n_err++; $display("FAIL rr_master_d[%0d] got %0d want %0d", i, HMASTER_D, exp_d[i]); end
    end
  endtask

  task automatic test_burst_wait();
    apply_reset();
    HBUSREQ = 3'b100;
    tick();
    n_cmp++; if (HMASTER !== 2'd2) begin n_err++; $display("FAIL bw_own got %0d want 2", HMASTER); end
    HBUSREQ = 3'b111;
    HTRANS  = TRANS_NONSEQ;
    HBURST  = 3'b010;
    tick();
    n_cmp++; if (HGRANT !== 3'b100) begin n_err++; $display("FAIL bw_beat1 got %b want 100", HGRANT); end
    n_cmp++; if (dut.state !== ST_BURST) begin n_err++; $display("FAIL bw_state got %0d want BURST", dut.state); end
    HTRANS = TRANS_SEQ;
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (HGRANT !== 3'b100) begin n_err++; $display("FAIL bw_wait[%0d] got %b want 100", i, HGRANT); end
    end
    HREADY = 1'b1;
    tick();
    tick();
    n_cmp++; if (HGRANT !== 3'b100) begin n_err++; $display("FAIL bw_beat3 got %b want 100", HGRANT); end
    tick();
    n_cmp++; if (HGRANT !== 3'b001) begin n_err++; $display("FAIL bw_handover got %b want 001", HGRANT); end
    n_cmp++; if (HMASTER !== 2'd0) begin n_err++; $display("FAIL bw_master got %0d want 0", HMASTER); end
    n_cmp++; if (HMASTER_D !== 2'd2) begin n_err++; $display("FAIL bw_master_d got %0d want 2", HMASTER_D); end
  endtask

  task automatic test_lock();
    apply_reset();
    HBUSREQ = 3'b010;
    HLOCK   = 3'b010;
    tick();
    n_cmp++; if (HMASTER !== 2'd1) begin n_err++; $display("FAIL lk_grant got %0d want 1", HMASTER); end
    n_cmp++; if (HMASTLOCK !== 1'b1) begin n_err++; $display("FAIL lk_lock got %b want 1", HMASTLOCK); end
    HBUSREQ = 3'b111;
    HTRANS  = TRANS_NONSEQ;
    HBURST  = BURST_SINGLE;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (HMASTER !== 2'd1) begin n_err++; $display("FAIL lk_hold[%0d] got %0d want 1", i, HMASTER); end
      n_cmp++; if (HMASTLOCK !== 1'b1) begin n_err++; $display("FAIL lk_hold_lock[%0d] got %b want 1", i, HMASTLOCK); end
    end
    HLOCK = 3'b000;
    tick();
    n_cmp++; if (HMASTER !== 2'd2) begin n_err++; $display("FAIL lk_release got %0d want 2", HMASTER); end
    n_cmp++; if (HMASTLOCK !== 1'b0) begin n_err++; $display("FAIL lk_release_lock got %b want 0", HMASTLOCK); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    HBUSREQ = 3'b100;
    tick();
    HTRANS = TRANS_NONSEQ;
    HBURST = 3'b100;
    tick();
    HTRANS = TRANS_SEQ;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (dut.cnt !== 5'd4) begin n_err++; $display("FAIL mr_count got %0d want 4", dut.cnt); end
    n_cmp++; if (HMASTER_D !== 2'd2) begin n_err++; $display("FAIL mr_pre_d got %0d want 2", HMASTER_D); end
    #3;
    HRESET = 1'b1;
    #1;
    n_cmp++; if (HGRANT !== 3'b001) begin n_err++; $display("FAIL mr_grant got %b want 001", HGRANT); end
    n_cmp++; if (HMASTER !== 2'd0) begin n_err++; $display("FAIL mr_master got %0d want 0", HMASTER); end
    n_cmp++; if (HMASTER_D !== 2'd0) begin n_err++; $display("FAIL mr_master_d got %0d want 0", HMASTER_D); end
    n_cmp++; if (dut.state !== ST_PARK) begin n_err++; $display("FAIL mr_state got %0d want PARK", dut.state); end
    n_cmp++; if (dut.cnt !== 5'd0) begin n_err++; $display("FAIL mr_cnt got %0d want 0", dut.cnt); end
    HRESET  = 1'b0;
    HBUSREQ = 3'b111;
    HTRANS  = TRANS_NONSEQ;
    HBURST  = BURST_SINGLE;
    tick();
    n_cmp++; if (HMASTER !== 2'd1) begin n_err++; $display("FAIL mr_resume got %0d want 1", HMASTER); end
  endtask

  task automatic test_handover_wait();
    apply_reset();
    HBUSREQ = 3'b100;
    tick();
    HBUSREQ = 3'b010;
    tick();
    n_cmp++; if (HMASTER !== 2'd1) begin n_err++; $display("FAIL hw_master got %0d want 1", HMASTER); end
    n_cmp++; if (HMASTER_D !== 2'd2) begin n_err++; $display("FAIL hw_d0 got %0d want 2", HMASTER_D); end
    HREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (HMASTER_D !== 2'd2) begin n_err++; $display("FAIL hw_hold_d[%0d] got %0d want 2", i, HMASTER_D); end
      n_cmp++; if (HMASTER !== 2'd1) begin n_err++; $display("FAIL hw_hold_m[%0d] got %0d want 1", i, HMASTER); end
    end
    HREADY = 1'b1;
    tick();
    n_cmp++; if (HMASTER_D !== 2'd1) begin n_err++; $display("FAIL hw_d1 got %0d want 1", HMASTER_D); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst_wait();
    test_lock();
    test_reset_mid_burst();
    test_handover_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
